// File: rtl/project_pkg.sv
// Shared matrix types, dimension limits, FSM encodings and the input error enum
// used by the matrix input parser.
package project_pkg;

   localparam int MAX_ROWS  = 4;
   localparam int MAX_COLS  = 4;
   localparam int ROW_IDX_W = $clog2(MAX_ROWS);
   localparam int COL_IDX_W = $clog2(MAX_COLS);
   // Wide enough to hold the dimension count itself (1..MAX), not just an index.
   localparam int DIM_W     = $clog2(((MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS) + 1);

   typedef logic signed [7:0] matrix_element_t;

   typedef struct packed {
      logic [DIM_W-1:0]                                 rows;
      logic [DIM_W-1:0]                                 cols;
      matrix_element_t [MAX_ROWS-1:0][MAX_COLS-1:0]     cells;
   } matrix_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_DIM     = 2'd1,
      ERR_ELEM    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } input_err_t;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_M    = 3'd1;
   localparam logic [2:0] ST_WAIT_N    = 3'd2;
   localparam logic [2:0] ST_WAIT_ELEM = 3'd3;
   localparam logic [2:0] ST_WRITE     = 3'd4;
   localparam logic [2:0] ST_EXIT_WAIT = 3'd5;

   function automatic logic dim_ok(input logic [7:0] b, input int max_dim);
      return (b != 8'd0) && (int'(b) <= max_dim);
   endfunction

endpackage

// File: rtl/input_timeout_counter.sv
// Idle-cycle counter for the parser's byte timeout; only instantiated when
// INPUT_TIMEOUT_EN is defined.
module input_timeout_counter
   import project_pkg::*;
#(
   parameter int unsigned LIMIT = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [31:0] cnt;

   // Saturates at LIMIT so expired stays asserted until cleared.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         cnt <= '0;
      end else if (enable && !expired) begin
         cnt <= cnt + 32'd1;
      end
   end

   assign expired = (cnt == LIMIT);

endmodule

// File: rtl/matrix_input_parser.sv
// Parses a UART byte stream (m, n, m*n signed elements) into a matrix_t and hands
// it to storage over a wr_en/wr_ready handshake. Optional timeout: INPUT_TIMEOUT_EN.
module matrix_input_parser
   import project_pkg::*;
#(
   parameter int ELEM_MIN       = 0,
   parameter int ELEM_MAX       = 9,
   parameter int TIMEOUT_CYCLES = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_en,
   input  logic       btn_quit,
   input  logic [7:0] rx_data,
   input  logic       rx_done,
   output logic       wr_en,
   output matrix_t    wr_data,
   input  logic       wr_ready,
   output logic       err_pulse,
   output input_err_t err_code,
   output logic       input_done,
   output logic       input_active,
   output logic [2:0] state_dbg
);

   logic [2:0]           state;
   logic [DIM_W-1:0]     m_reg;
   logic [DIM_W-1:0]     n_reg;
   logic [ROW_IDX_W-1:0] cur_r;
   logic [COL_IDX_W-1:0] cur_c;
   logic                 quit_pend;
   logic                 timeout_hit;
   logic signed [7:0]    elem;
   logic                 elem_ok;
   logic                 dim_m_ok;
   logic                 dim_n_ok;
   logic                 last_col;
   logic                 last_row;

   always_comb begin
      elem     = signed'(rx_data);
      elem_ok  = (int'(elem) >= ELEM_MIN) && (int'(elem) <= ELEM_MAX);
      dim_m_ok = dim_ok(rx_data, MAX_ROWS);
      dim_n_ok = dim_ok(rx_data, MAX_COLS);
      last_col = (DIM_W'(cur_c) == (n_reg - DIM_W'(1)));
      last_row = (DIM_W'(cur_r) == (m_reg - DIM_W'(1)));
   end

`ifdef INPUT_TIMEOUT_EN
   logic to_en;
   logic to_clear;
   logic to_expired;

   // Clearing whenever outside WAIT_N/WAIT_ELEM restarts the count on entry.
   assign to_en    = (state == ST_WAIT_N) || (state == ST_WAIT_ELEM);
   assign to_clear = rx_done || !to_en;

   input_timeout_counter #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (to_clear),
      .enable  (to_en),
      .expired (to_expired)
   );

   assign timeout_hit = to_en && to_expired;
`else
   // Never true: without the timeout feature the parser waits indefinitely.
   assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

   // Write handshake: wr_en rises with wr_data fully assembled and both hold
   // unchanged until a cycle with wr_en && wr_ready; wr_en drops the next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wr_en      <= 1'b0;
         wr_data    <= '0;
         err_pulse  <= 1'b0;
         err_code   <= ERR_NONE;
         input_done <= 1'b0;
         m_reg      <= '0;
         n_reg      <= '0;
         cur_r      <= '0;
         cur_c      <= '0;
         quit_pend  <= 1'b0;
      end else begin
         err_pulse  <= 1'b0;
         input_done <= 1'b0;
         if (!start_en) begin
            state     <= ST_IDLE;
            wr_en     <= 1'b0;
            quit_pend <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state   <= ST_WAIT_M;
                  wr_data <= '0;
               end
               ST_WAIT_M: begin
                  if (btn_quit) begin
                     state      <= ST_EXIT_WAIT;
                     input_done <= 1'b1;
                     wr_data    <= '0;
                  end else if (rx_done) begin
                     if (dim_m_ok) begin
                        m_reg <= rx_data[DIM_W-1:0];
                        state <= ST_WAIT_N;
                     end else begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_DIM;
                     end
                  end
               end
               ST_WAIT_N: begin
                  if (btn_quit) begin
                     state      <= ST_EXIT_WAIT;
                     input_done <= 1'b1;
                     wr_data    <= '0;
                  end else if (rx_done) begin
                     if (dim_n_ok) begin
                        n_reg <= rx_data[DIM_W-1:0];
                        cur_r <= '0;
                        cur_c <= '0;
                        state <= ST_WAIT_ELEM;
                     end else begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_DIM;
                        state     <= ST_WAIT_M;
                        wr_data   <= '0;
                     end
                  end else if (timeout_hit) begin
                     err_pulse <= 1'b1;
                     err_code  <= ERR_TIMEOUT;
                     state     <= ST_WAIT_M;
                     wr_data   <= '0;
                  end
               end
               ST_WAIT_ELEM: begin
                  if (btn_quit) begin
                     state      <= ST_EXIT_WAIT;
                     input_done <= 1'b1;
                     wr_data    <= '0;
                  end else if (rx_done) begin
                     if (elem_ok) begin
                        wr_data.cells[cur_r][cur_c] <= elem;
                        if (last_col) begin
                           cur_c <= '0;
                           if (last_row) begin
                              state        <= ST_WRITE;
                              wr_en        <= 1'b1;
                              wr_data.rows <= m_reg;
                              wr_data.cols <= n_reg;
                           end else begin
                              cur_r <= cur_r + ROW_IDX_W'(1);
                           end
                        end else begin
                           cur_c <= cur_c + COL_IDX_W'(1);
                        end
                     end else begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_ELEM;
                        state     <= ST_WAIT_M;
                        wr_data   <= '0;
                     end
                  end else if (timeout_hit) begin
                     err_pulse <= 1'b1;
                     err_code  <= ERR_TIMEOUT;
                     state     <= ST_WAIT_M;
                     wr_data   <= '0;
                  end
               end
               ST_WRITE: begin
                  if (btn_quit) begin
                     quit_pend <= 1'b1;
                  end
                  if (wr_ready) begin
                     wr_en <= 1'b0;
                     if (quit_pend || btn_quit) begin
                        quit_pend  <= 1'b0;
                        input_done <= 1'b1;
                        state      <= ST_EXIT_WAIT;
                     end else begin
                        state <= ST_WAIT_M;
                     end
                     wr_data <= '0;
                  end
               end
               ST_EXIT_WAIT: begin
                  state <= ST_EXIT_WAIT;
               end
               default: begin
                  state <= ST_IDLE;
                  wr_en <= 1'b0;
               end
            endcase
         end
      end
   end

   assign input_active = (state != ST_IDLE);
   assign state_dbg    = state;

endmodule

// File: tb/tb_matrix_input_parser.sv
// Self-checking bench for matrix_input_parser: table of byte streams plus
// hand-written sequences for backpressure, quit, start_en drop, timeout and reset.
module tb_matrix_input_parser;
   import project_pkg::*;

   localparam int MW = $bits(matrix_t);
   localparam int SW = 160;

   typedef struct {
      int            nb;
      logic [SW-1:0] stream;
      bit            exp_wr;
      input_err_t    exp_err;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_en;
   logic       btn_quit;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       wr_en;
   matrix_t    wr_data;
   logic       wr_ready;
   logic       err_pulse;
   input_err_t err_code;
   logic       input_done;
   logic       input_active;
   logic [2:0] state_dbg;

   int checks = 0;
   int errors = 0;
   int write_cnt = 0;
   int done_cnt = 0;
   int err_cnt = 0;

   logic [MW-1:0] exp_q[$];
   logic [1:0]    err_exp_q[$];

   logic          prev_wr_en = 1'b0;
   logic          prev_xfer = 1'b0;
   logic          prev_err = 1'b0;
   logic          prev_done = 1'b0;
   logic [MW-1:0] prev_data = '0;

   vec_t tbl[14];
   vec_t v;
   int   w0, d0, e0, k;

   matrix_input_parser #(
      .ELEM_MIN       (0),
      .ELEM_MAX       (9),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_en     (start_en),
      .btn_quit     (btn_quit),
      .rx_data      (rx_data),
      .rx_done      (rx_done),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .err_pulse    (err_pulse),
      .err_code     (err_code),
      .input_done   (input_done),
      .input_active (input_active),
      .state_dbg    (state_dbg)
   );

   // Clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_wide(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en && wr_ready) begin
            write_cnt++;
            chk("write_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) chk_wide("write_data", wr_data, exp_q.pop_front());
         end
         if (wr_en && prev_wr_en && !prev_xfer) chk_wide("wr_data_stable", wr_data, prev_data);
         if (err_pulse) begin
            err_cnt++;
            chk("err_expected", err_exp_q.size() > 0, 1);
            if (err_exp_q.size() > 0) chk("err_code", err_code, err_exp_q.pop_front());
            chk("err_pulse_width", prev_err, 0);
         end
         if (input_done) begin
            done_cnt++;
            chk("done_pulse_width", prev_done, 0);
         end
      end
      prev_wr_en = wr_en;
      prev_xfer  = wr_en && wr_ready;
      prev_err   = err_pulse;
      prev_done  = input_done;
      prev_data  = wr_data;
   end

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   function automatic vec_t mk(input int nb, input logic [SW-1:0] s, input bit wr, input input_err_t e);
      vec_t r;
      r.nb = nb;
      r.stream = s;
      r.exp_wr = wr;
      r.exp_err = e;
      return r;
   endfunction

   function automatic logic [7:0] get_byte(input vec_t vv, input int i);
      return vv.stream[8*(vv.nb-1-i) +: 8];
   endfunction

   // Reference model: row-major fill of an all-zero matrix
   function automatic matrix_t model_matrix(input vec_t vv);
      matrix_t mm;
      int m, n;
      mm = '0;
      m = int'(get_byte(vv, 0));
      n = int'(get_byte(vv, 1));
      mm.rows = DIM_W'(m);
      mm.cols = DIM_W'(n);
      for (int r = 0; r < m; r++)
         for (int c = 0; c < n; c++)
            mm.cells[r][c] = get_byte(vv, 2 + r*n + c);
      return mm;
   endfunction

   task automatic push_expect(input vec_t vv);
      if (vv.exp_wr) exp_q.push_back(model_matrix(vv));
      if (vv.exp_err != ERR_NONE) err_exp_q.push_back(vv.exp_err);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic send_vec(input vec_t vv);
      for (int i = 0; i < vv.nb; i++) send_byte(get_byte(vv, i));
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || err_exp_q.size() != 0) && n < 40) begin
         tick();
         n++;
      end
      chk("drain_pending", exp_q.size() + err_exp_q.size(), 0);
      exp_q.delete();
      err_exp_q.delete();
   endtask

   task automatic wait_wr_en();
      int n = 0;
      while (!wr_en && n < 10) begin
         tick();
         n++;
      end
      chk("wr_en_rise", wr_en, 1);
   endtask

   initial begin
      rst_n = 1'b0; start_en = 1'b0; btn_quit = 1'b0;
      rx_done = 1'b0; rx_data = 8'd0; wr_ready = 1'b1;
      repeat (3) tick();
      at_neg();
      chk("rst_state", state_dbg, ST_IDLE);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_err_code", err_code, ERR_NONE);
      chk("rst_err_pulse", err_pulse, 0);
      chk("rst_input_done", input_done, 0);
      chk("rst_active", input_active, 0);
      chk_wide("rst_wr_data", wr_data, '0);
      tick();
      rst_n = 1'b1;
      tick();
      start_en = 1'b1;
      tick();
      at_neg();
      chk("start_state", state_dbg, ST_WAIT_M);
      chk("start_active", input_active, 1);

      tbl[0]  = mk(8,  SW'({8'h02, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}), 1, ERR_NONE);
      tbl[1]  = mk(1,  SW'({8'h06}), 0, ERR_DIM);
      tbl[2]  = mk(3,  SW'({8'h01, 8'h01, 8'h07}), 1, ERR_NONE);
      tbl[3]  = mk(4,  SW'({8'h02, 8'h02, 8'h01, 8'h0A}), 0, ERR_ELEM);
      tbl[4]  = mk(3,  SW'({8'h01, 8'h01, 8'h09}), 1, ERR_NONE);
      tbl[5]  = mk(18, SW'({8'h04, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
                            8'h07, 8'h08, 8'h09, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04}), 1, ERR_NONE);
      tbl[6]  = mk(1,  SW'({8'h00}), 0, ERR_DIM);
      tbl[7]  = mk(2,  SW'({8'h02, 8'h05}), 0, ERR_DIM);
      tbl[8]  = mk(2,  SW'({8'h02, 8'h00}), 0, ERR_DIM);
      tbl[9]  = mk(6,  SW'({8'h01, 8'h04, 8'h09, 8'h00, 8'h09, 8'h00}), 1, ERR_NONE);
      tbl[10] = mk(3,  SW'({8'h03, 8'h01, 8'hFF}), 0, ERR_ELEM);
      tbl[11] = mk(8,  SW'({8'h03, 8'h02, 8'h00, 8'h09, 8'h05, 8'h00, 8'h09, 8'h01}), 1, ERR_NONE);
      tbl[12] = mk(2,  SW'({8'h04, 8'hFF}), 0, ERR_DIM);
      tbl[13] = mk(4,  SW'({8'h02, 8'h01, 8'h03, 8'h08}), 1, ERR_NONE);

      for (int i = 0; i < 14; i++) begin
         push_expect(tbl[i]);
         send_vec(tbl[i]);
         drain();
         at_neg();
         chk("vec_end_state", state_dbg, ST_WAIT_M);
      end

      // Backpressure: wr_en/wr_data held, exactly one transfer
      tick();
      wr_ready = 1'b0;
      v = mk(4, SW'({8'h01, 8'h02, 8'h03, 8'h04}), 1, ERR_NONE);
      push_expect(v);
      send_vec(v);
      wait_wr_en();
      w0 = write_cnt;
      for (int j = 0; j < 5; j++) begin
         at_neg();
         chk("bp_wr_en_held", wr_en, 1);
         chk("bp_state", state_dbg, ST_WRITE);
         tick();
      end
      chk("bp_no_early_write", write_cnt - w0, 0);
      wr_ready = 1'b1;
      tick();
      chk("bp_one_write", write_cnt - w0, 1);
      at_neg();
      chk("bp_wr_en_drop", wr_en, 0);
      chk("bp_state_after", state_dbg, ST_WAIT_M);

      // Quit with simultaneous byte mid-matrix
      tick();
      v = mk(3, SW'({8'h02, 8'h02, 8'h01}), 0, ERR_NONE);
      send_vec(v);
      d0 = done_cnt; w0 = write_cnt;
      rx_data = 8'h02; rx_done = 1'b1; btn_quit = 1'b1;
      tick();
      rx_done = 1'b0; btn_quit = 1'b0;
      at_neg();
      chk("quit_done", input_done, 1);
      chk("quit_state", state_dbg, ST_EXIT_WAIT);
      tick();
      chk("quit_done_once", done_cnt - d0, 1);
      start_en = 1'b0;
      tick();
      at_neg();
      chk("quit_idle", state_dbg, ST_IDLE);
      chk("quit_inactive", input_active, 0);
      chk("quit_no_write", write_cnt - w0, 0);
      tick();
      start_en = 1'b1;
      tick();

      // Quit during WRITE is deferred until the transfer completes
      wr_ready = 1'b0;
      v = mk(3, SW'({8'h01, 8'h01, 8'h05}), 1, ERR_NONE);
      push_expect(v);
      send_vec(v);
      wait_wr_en();
      d0 = done_cnt;
      btn_quit = 1'b1;
      tick();
      btn_quit = 1'b0;
      at_neg();
      chk("defer_state", state_dbg, ST_WRITE);
      chk("defer_no_done", input_done, 0);
      chk("defer_wr_en", wr_en, 1);
      tick();
      wr_ready = 1'b1;
      tick();
      at_neg();
      chk("defer_done", input_done, 1);
      chk("defer_exit", state_dbg, ST_EXIT_WAIT);
      chk("defer_wr_en_drop", wr_en, 0);
      tick();
      chk("defer_done_once", done_cnt - d0, 1);
      chk("defer_written", exp_q.size(), 0);
      start_en = 1'b0;
      tick();
      at_neg();
      chk("defer_idle", state_dbg, ST_IDLE);
      tick();
      start_en = 1'b1;
      tick();

      // start_en drop mid-matrix: no write, no done, partial cells cleared
      v = mk(4, SW'({8'h02, 8'h02, 8'h01, 8'h02}), 0, ERR_NONE);
      send_vec(v);
      d0 = done_cnt; w0 = write_cnt;
      start_en = 1'b0;
      tick();
      at_neg();
      chk("drop_idle", state_dbg, ST_IDLE);
      chk("drop_no_done", input_done, 0);
      tick();
      chk("drop_done_cnt", done_cnt - d0, 0);
      chk("drop_write_cnt", write_cnt - w0, 0);
      start_en = 1'b1;
      tick();
      at_neg();
      chk("drop_restart", state_dbg, ST_WAIT_M);
      v = mk(3, SW'({8'h01, 8'h01, 8'h03}), 1, ERR_NONE);
      push_expect(v);
      send_vec(v);
      drain();

      // Silence in WAIT_ELEM
      v = mk(3, SW'({8'h03, 8'h03, 8'h01}), 0, ERR_NONE);
      send_vec(v);
      e0 = err_cnt;
`ifdef INPUT_TIMEOUT_EN
      err_exp_q.push_back(ERR_TIMEOUT);
      k = 0;
      while (err_exp_q.size() != 0 && k < 80) begin
         tick();
         k++;
      end
      chk("timeout_fired", err_exp_q.size(), 0);
      chk("timeout_not_early", k >= 45, 1);
      at_neg();
      chk("timeout_state", state_dbg, ST_WAIT_M);
`else
      repeat (120) tick();
      chk("no_timeout_err", err_cnt - e0, 0);
      at_neg();
      chk("no_timeout_state", state_dbg, ST_WAIT_ELEM);
      tick();
      start_en = 1'b0;
      tick();
      start_en = 1'b1;
      tick();
`endif

      // Reset mid-matrix
      tick();
      v = mk(3, SW'({8'h02, 8'h02, 8'h01}), 0, ERR_NONE);
      send_vec(v);
      rst_n = 1'b0;
      tick();
      at_neg();
      chk("mid_rst_state", state_dbg, ST_IDLE);
      chk("mid_rst_wr_en", wr_en, 0);
      chk("mid_rst_err_code", err_code, ERR_NONE);
      chk("mid_rst_active", input_active, 0);
      chk_wide("mid_rst_wr_data", wr_data, '0);
      tick();
      rst_n = 1'b1;
      tick();
      v = mk(3, SW'({8'h01, 8'h01, 8'h04}), 1, ERR_NONE);
      push_expect(v);
      send_vec(v);
      drain();

      repeat (3) tick();
      chk("final_exp_q", exp_q.size(), 0);
      chk("final_err_q", err_exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
